wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Writeback trace capture buffer on the CPU debug port. Samples `debug_wb_pc` / `debug_wb_rf_wen` / `debug_wb_rf_wnum` / `debug_wb_rf_wdata` every cycle and queues each qualifying register-file write as one trace entry. A trace comparator or UART dumper drains the entries through a valid/ready stream. Overflow is sticky and counted; it never stalls the core.

## Interface
- `DEPTH`, 16: entry count; power of two, 4..256.
- `AW`, 4: pointer width, log2(DEPTH).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `capture_en` in 1: capture qualifier; 0 suppresses all pushes.
- `clear` in 1: synchronous flush of queue and status.
- `debug_wb_pc` in 32: writeback PC.
- `debug_wb_rf_wen` in 4: byte write enables.
- `debug_wb_rf_wnum` in 5: destination register.
- `debug_wb_rf_wdata` in 32: write data.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head.
- `out_pc` out 32: head PC.
- `out_wnum` out 5: head register number.
- `out_wdata` out 32: head data.
- `out_wen` out 4: head byte enables.
- `count` out AW+1: occupied entries, 0..DEPTH.
- `overflow` out 1: sticky; a qualifying write was dropped.
- `drop_cnt` out 16: dropped writes, saturating at 16'hFFFF.

## Operation
- Qualifying write: `capture_en & (|debug_wb_rf_wen) & (debug_wb_rf_wnum != 0)`.
- Entry = {pc, wnum, wdata, wen}, 73 bits, in a register array of DEPTH entries.
- Pointers: `wr_ptr`, `rd_ptr` are AW bits and wrap modulo DEPTH. Occupancy is tracked in `count`.
- Pop: `out_valid & out_ready`. The read pointer advances and `count` decrements.
- Push accepted when qualifying and (`count < DEPTH` or pop in the same cycle).
  - The entry is written at `wr_ptr`, which then advances.
  - `count` is unchanged on simultaneous push+pop.
- Drop: qualifying while `count == DEPTH` and no pop.
  - Entry is discarded.
  - `overflow` sets to 1.
  - `drop_cnt` increments, saturating.
  - Queue contents are untouched.
- Empty with push, no pop: the entry is stored and appears at the head next cycle. There is no same-cycle bypass.
- `clear` has priority over push, pop and drop in its cycle.
  - Pointers, `count`, `overflow` and `drop_cnt` go to 0.
  - That cycle's qualifying write is discarded and not counted.
- Head outputs are combinational from `rd_ptr` (first-word fall-through).
  - `out_valid = (count != 0)`.
  - Head fields are don't-care when `out_valid = 0`; the bench checks them only when valid.
- Head stability: while `out_valid & ~out_ready`, all head fields hold stable regardless of pushes.
- Array contents are not reset; only control state is reset.

## Timing
- Reset (async assert, sync-safe deassert by the integrator):
  - `count = 0`, `out_valid = 0`, `overflow = 0`, `drop_cnt = 0`.
  - Head fields 0 on reset; after reset they are don't-care until the first push.
- Capture latency is 1 cycle: a qualifying write at edge N is visible at the head after edge N, if the queue was empty.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- `count` and `overflow` update on the same edge as the causing push, pop or drop.
- Reset mid-stream: all entries are lost immediately, asynchronously, without waiting for a clock edge.

## Test plan
- Reset, then one write (pc=0xBFC00000, wen=4'hF, wnum=2, wdata=0x1234) -> next cycle `out_valid = 1` with those fields and `count = 1`. `out_ready = 1` -> `count = 0`, `out_valid = 0`.
- Filtering: wen=0, or wnum=0, or `capture_en = 0` for 10 cycles -> `count` stays 0 and `drop_cnt` stays 0.
- Fill with `out_ready = 0`: DEPTH+3 consecutive writes -> `count = 16`, `overflow = 1`, `drop_cnt = 3`. Draining yields the first 16 entries in order.
- Full with simultaneous push+pop: `count` stays 16, no drop, and the new entry lands last. Wrap-around holds over 40 cycles of streaming with no loss or reordering.
- `clear` asserted with a qualifying write while holding 5 entries -> next cycle `count = 0`, `overflow = 0`, `drop_cnt = 0`, `out_valid = 0`.
- Async `reset` pulse mid-cycle with 7 entries -> `out_valid` and `count` drop to 0 before the next edge. Resume capture normally afterwards.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: writeback trace capture buffer.
// Queues qualifying register-file writes from the CPU debug port and drains
// them through a first-word fall-through valid/ready stream. A full queue
// drops new writes instead of stalling the core, and records the loss in a
// sticky flag and a saturating counter.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          capture_en,
  input  logic          clear,
  input  logic [31:0]   debug_wb_pc,
  input  logic [3:0]    debug_wb_rf_wen,
  input  logic [4:0]    debug_wb_rf_wnum,
  input  logic [31:0]   debug_wb_rf_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_wnum,
  output logic [31:0]   out_wdata,
  output logic [3:0]    out_wen,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

  // Entry layout: {pc[72:41], wnum[40:36], wdata[35:4], wen[3:0]}
  logic [72:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic          w_qual;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [72:0]   w_head;

  assign w_qual = capture_en & (|debug_wb_rf_wen) & (debug_wb_rf_wnum != 5'd0);
  assign w_full = (r_count == LP_FULL);
  assign out_valid = (r_count != '0);
  assign w_pop  = out_valid & out_ready;
  // A full queue can still accept a write when the head leaves in the same cycle.
  assign w_push = w_qual & (~w_full | w_pop);
  assign w_drop = w_qual & w_full & ~w_pop;

  // Head fields are forced to zero while empty so reset presents a clean head.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_pc    = out_valid ? w_head[72:41] : 32'd0;
  assign out_wnum  = out_valid ? w_head[40:36] : 5'd0;
  assign out_wdata = out_valid ? w_head[35:4]  : 32'd0;
  assign out_wen   = out_valid ? w_head[3:0]   : 4'd0;

  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_rf_wen};
    end
  end

  // Control state: pointers, occupancy and drop status, with clear taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: randomized scoreboard bench for wb_trace_fifo.
// The stimulus process drives the debug port and keeps a queue-level model of
// what the buffer should hold; a negedge monitor compares the presented head
// and status against that model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset;
  logic          captureEn;
  logic          clear;
  logic [31:0]   wbPc;
  logic [3:0]    wbWen;
  logic [4:0]    wbWnum;
  logic [31:0]   wbWdata;
  logic          outValid;
  logic          outReady;
  logic [31:0]   outPc;
  logic [4:0]    outWnum;
  logic [31:0]   outWdata;
  logic [3:0]    outWen;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   dropCnt;

  int            compared;
  int            mismatched;
  bit            monOn;

  // Reference model state
  logic [72:0]   sb[$];
  int            mCount;
  bit            mOverflow;
  int            mDrops;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .capture_en(captureEn),
    .clear(clear),
    .debug_wb_pc(wbPc),
    .debug_wb_rf_wen(wbWen),
    .debug_wb_rf_wnum(wbWnum),
    .debug_wb_rf_wdata(wbWdata),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_pc(outPc),
    .out_wnum(outWnum),
    .out_wdata(outWdata),
    .out_wen(outWen),
    .count(count),
    .overflow(overflow),
    .drop_cnt(dropCnt)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the model on the capturing edge.
  task automatic applyStimulus(input bit en, input logic [3:0] wen, input logic [4:0] wnum,
                               input logic [31:0] pc, input logic [31:0] wdata,
                               input bit rdy, input bit clr);
    bit qual;
    bit pop;
    captureEn = en;
    wbWen     = wen;
    wbWnum    = wnum;
    wbPc      = pc;
    wbWdata   = wdata;
    outReady  = rdy;
    clear     = clr;
    @(posedge clk);
    qual = en && (wen != 4'd0) && (wnum != 5'd0);
    if (clr) begin
      sb.delete();
      mCount    = 0;
      mOverflow = 1'b0;
      mDrops    = 0;
    end else begin
      pop = (mCount > 0) && rdy;
      if (qual && (mCount < DEPTH || pop)) begin
        sb.push_back({pc, wnum, wdata, wen});
        mCount = mCount + (pop ? 0 : 1);
      end else begin
        if (pop) mCount = mCount - 1;
        if (qual) begin
          mOverflow = 1'b1;
          if (mDrops < 65535) mDrops = mDrops + 1;
        end
      end
    end
    #1;
  endtask

  task automatic writeRandom(input bit rdy);
    applyStimulus(1'b1, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)),
                  $urandom, $urandom, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  // Monitor: compare status every cycle and the head whenever it is presented;
  // the scoreboard entry retires when the consumer accepts it.
  always @(negedge clk) begin
    logic [72:0] e;
    if (monOn && !reset) begin
      checkOutput("valid", 32'(outValid), 32'(mCount != 0));
      checkOutput("count", 32'(count), 32'(mCount));
      checkOutput("overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("drop_cnt", 32'(dropCnt), 32'(mDrops));
      if (outValid) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL head_unexpected: got valid=1 expected empty queue at %0t", $time);
        end else begin
          e = sb[0];
          checkOutput("head_pc", outPc, e[72:41]);
          checkOutput("head_wnum", 32'(outWnum), 32'(e[40:36]));
          checkOutput("head_wdata", outWdata, e[35:4]);
          checkOutput("head_wen", 32'(outWen), 32'(e[3:0]));
          if (outReady) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    monOn      = 1'b0;
    mCount     = 0;
    mOverflow  = 1'b0;
    mDrops     = 0;
    reset      = 1'b1;
    captureEn  = 1'b0;
    clear      = 1'b0;
    wbPc       = '0;
    wbWen      = '0;
    wbWnum     = '0;
    wbWdata    = '0;
    outReady   = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
    checkOutput("rst_head_pc", outPc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    monOn = 1'b1;

    // Single capture with one-cycle latency, then pop
    applyStimulus(1'b1, 4'hF, 5'd2, 32'hBFC0_0000, 32'h0000_1234, 1'b0, 1'b0);
    checkOutput("first_valid", 32'(outValid), 32'd1);
    checkOutput("first_pc", outPc, 32'hBFC0_0000);
    checkOutput("first_wdata", outWdata, 32'h0000_1234);
    checkOutput("first_count", 32'(count), 32'd1);
    idle(1'b0);
    idle(1'b1);
    checkOutput("first_pop_count", 32'(count), 32'd0);
    checkOutput("first_pop_valid", 32'(outValid), 32'd0);

    // Filtering: nothing qualifies
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0: applyStimulus(1'b1, 4'd0, 5'd7, $urandom, $urandom, 1'($urandom), 1'b0);
        1: applyStimulus(1'b1, 4'hF, 5'd0, $urandom, $urandom, 1'($urandom), 1'b0);
        default: applyStimulus(1'b0, 4'hF, 5'd9, $urandom, $urandom, 1'($urandom), 1'b0);
      endcase
    end
    checkOutput("filter_count", 32'(count), 32'd0);
    checkOutput("filter_drops", 32'(dropCnt), 32'd0);

    // Fill past capacity with the consumer stalled
    for (int i = 0; i < DEPTH + 3; i++) writeRandom(1'b0);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    checkOutput("fill_drops", 32'(dropCnt), 32'd3);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    checkOutput("drain_count", 32'(count), 32'd0);

    // Full queue with simultaneous push and pop, streaming across wrap-around
    for (int i = 0; i < DEPTH; i++) writeRandom(1'b0);
    for (int i = 0; i < 40; i++) writeRandom(1'b1);
    checkOutput("stream_count", 32'(count), 32'd16);
    checkOutput("stream_drops", 32'(dropCnt), 32'd3);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Clear beats a qualifying write
    for (int i = 0; i < 5; i++) writeRandom(1'b0);
    applyStimulus(1'b1, 4'h3, 5'd4, 32'h1000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checkOutput("clear_count", 32'(count), 32'd0);
    checkOutput("clear_overflow", 32'(overflow), 32'd0);
    checkOutput("clear_drops", 32'(dropCnt), 32'd0);
    checkOutput("clear_valid", 32'(outValid), 32'd0);

    // Asynchronous reset between edges with 7 entries held
    for (int i = 0; i < 7; i++) writeRandom(1'b0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(outValid), 32'd0);
    checkOutput("async_rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    sb.delete();
    mCount    = 0;
    mOverflow = 1'b0;
    mDrops    = 0;
    #1;

    // Randomized traffic with occasional filtering, stalls and clears
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                    5'($urandom_range(0, 31)), $urandom, $urandom,
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    checkOutput("final_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
